ni_flit_bridge: RTL and testbench
=================================

Name: ni_flit_bridge

Overview:
Parametrised network interface between the NoC flit port and the request/response FIFOs. Successor to the fixed 16-bit, 5-flit NI.
- Generalises flit width and body-flit count.
- Adds valid/ready backpressure on both NoC directions.
- Adds flit-type checking with protocol-error reporting.
- The request path deserialises head/body/tail flits into one packet word for the request FIFO; the response path reads packet words from the response FIFO and serialises them to the NoC.

Parameters:
FLIT_W, 16, flit width in bits; bits [FLIT_W-1:FLIT_W-2] carry flit type.
BODY_FLITS, 3, body flits per packet; legal range 1..15.
PKT_W, FLIT_W*(BODY_FLITS+2), packet word width (derived localparam, not overridable).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_flit  in  FLIT_W  flit from NoC
in_valid  in  1  in_flit valid
in_ready  out  1  bridge accepts in_flit
out_flit  out  FLIT_W  flit to NoC
out_valid  out  1  out_flit valid
out_ready  in  1  NoC accepts out_flit
req_fifo_wdata  out  PKT_W  assembled request packet
req_fifo_wreq  out  1  request FIFO write strobe
req_fifo_full  in  1  request FIFO full
resp_fifo_rdata  in  PKT_W  response packet, valid the cycle after rreq
resp_fifo_rreq  out  1  response FIFO read strobe
resp_fifo_empty  in  1  response FIFO empty
proto_err  out  1  one-cycle pulse on a flit-type violation

Behaviour:
- One clock: clk. Reset is synchronous, active-high, on port reset; all state updates on posedge clk.
- While reset is high, and in the cycle after it:
  - in_ready, out_valid, req_fifo_wreq, resp_fifo_rreq and proto_err are 0.
  - out_flit and req_fifo_wdata are 0.
  - Both FSMs are in their idle states; counters are 0.
- Flit types: IDLE=2'b00, HEAD=2'b01, BODY=2'b10, TAIL=2'b11. Flits are stored whole, type bits included.
- Packet layout: head at [FLIT_W-1:0]; body k (k=0..BODY_FLITS-1) at [(k+1)*FLIT_W +: FLIT_W]; tail at the top FLIT_W bits.
- A flit is accepted ("rx fire") when in_valid & in_ready; it is sent ("tx fire") when out_valid & out_ready.
- Request FSM (RX_HEAD, RX_BODY, RX_TAIL, RX_WRITE):
  - in_ready=1 in RX_HEAD, RX_BODY and RX_TAIL; 0 in RX_WRITE.
  - RX_HEAD:
    - Fire with HEAD: store the head, clear the body counter, go to RX_BODY.
    - Fire with any other type: drop the flit, pulse proto_err, stay.
  - RX_BODY:
    - Fire with BODY: store at the body-counter index and increment; after the BODY_FLITS-th body flit, go to RX_TAIL.
    - Fire with a non-BODY type: pulse proto_err, discard the partial packet, go to RX_HEAD. The offending flit is consumed, not re-parsed.
  - RX_TAIL:
    - Fire with TAIL: store it, go to RX_WRITE.
    - Fire with a non-TAIL type: pulse proto_err, discard, go to RX_HEAD.
  - RX_WRITE:
    - req_fifo_wreq = !req_fifo_full (combinational); req_fifo_wdata holds the assembled packet.
    - Move to RX_HEAD on the cycle wreq is high.
    - While the FIFO is full, hold state and data.
  - in_valid low in any state: no state change.
- Response FSM (TX_IDLE, TX_RREQ, TX_LOAD, TX_SEND):
  - TX_IDLE: if !resp_fifo_empty, go to TX_RREQ.
  - TX_RREQ: resp_fifo_rreq=1 for exactly one cycle, then TX_LOAD.
  - TX_LOAD: capture resp_fifo_rdata into a PKT_W shift buffer, zero the flit index, go to TX_SEND.
  - TX_SEND:
    - out_valid=1; out_flit = buffer flit at the current index, registered.
    - On tx fire, advance the index. When the tail fires (index BODY_FLITS+1), go to TX_IDLE.
    - out_flit must stay stable while out_valid & !out_ready.
  - Latency: from empty falling at cycle N, rreq is high at N+1, load at N+2, head valid at N+3.
  - Minimum gap between packets: 3 idle cycles on out_valid.
- The two paths are fully independent. Simultaneous rx fire and tx fire are legal every cycle.
- Reset asserted mid-packet abandons both paths immediately:
  - partial request packet discarded, no wreq issued;
  - an in-flight response packet is lost (the FIFO entry was already popped).
- Counter widths: $clog2(BODY_FLITS+2) bits; no wrap possible within legal BODY_FLITS.

Decomposition:
- Shared package ni_bridge_pkg:
  - flit_type_e enum (IDLE/HEAD/BODY/TAIL);
  - ni_rx_state_e and ni_tx_state_e enums;
  - FLIT_TYPE_W=2 constant;
  - function flit_type(flit) returning the top 2 bits.
- One sub-module, ni_tx_serializer: the TX_LOAD/TX_SEND buffer, index counter and out handshake, parametrised by FLIT_W and BODY_FLITS.
- The request FSM stays in the top module.

Test Plan:
- FLIT_W=16, BODY_FLITS=3: drive 0x4001, 0x8002, 0x8003, 0x8004, 0xC005 back-to-back with FIFO not full -> one wreq, wdata=0xC005_8004_8003_8002_4001, in_ready low exactly one cycle.
- Same packet with req_fifo_full high for 4 cycles after the tail -> wreq stays low 4 cycles, wdata stable, in_ready=0; wreq fires on the cycle full drops.
- Drive 0x8002 in RX_HEAD, then a head followed by 0xC009 as the first body -> proto_err pulses twice, no wreq; the next legal 5-flit packet is written correctly.
- resp_fifo_empty falls with rdata=0xC0AA_80BB_80CC_80DD_40EE and out_ready toggles 1,0,1,0,... -> rreq one cycle, head 0x40EE valid 3 cycles after empty falls, flits in order EE, DD, CC, BB, AA, each held through stall cycles.
- Full-duplex: request receive and response send overlapping in the same cycles -> both packets correct, no cross-interference.
- Assert reset after 2 flits of a request and 2 flits of a response -> all outputs 0 next cycle; a fresh 5-flit request then completes normally.

Source files
------------

// File: rtl/ni_bridge_pkg.sv
// Shared types and helpers for the NoC flit bridge.
//   flit_type_e   : 2-bit flit type carried in the top bits of every flit
//   ni_rx_state_e : request (deserialiser) FSM states
//   ni_tx_state_e : response (serialiser) FSM states
//   flit_type()   : extracts the type field from a flit of any width up to FLIT_MAX_W
package ni_bridge_pkg;

  localparam int FLIT_TYPE_W = 2;
  // Widest flit flit_type() can inspect. Callers zero-extend their flit to this width.
  localparam int FLIT_MAX_W  = 256;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10,
    TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    RX_HEAD,
    RX_BODY,
    RX_TAIL,
    RX_WRITE
  } ni_rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_RREQ,
    TX_LOAD,
    TX_SEND
  } ni_tx_state_e;

  // Returns bits [width-1:width-2] of a flit that has been zero-extended to FLIT_MAX_W.
  function automatic flit_type_e flit_type(input logic [FLIT_MAX_W-1:0] flit,
                                           input int                    width);
    return flit_type_e'(FLIT_TYPE_W'(flit >> (width - FLIT_TYPE_W)));
  endfunction

endpackage

// File: rtl/ni_tx_serializer.sv
// Response-side packet serialiser.
// Captures one packet word on i_load, then presents it to the NoC one flit at a
// time (head first, tail last) with a valid/ready handshake.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : capture i_rdata into the shift buffer this cycle
//   i_send       : FSM is in its send state; drives o_valid
//   i_rdata      : packet word from the response FIFO
//   i_ready      : NoC accepts o_flit
//   o_flit       : registered flit at the current index
//   o_valid      : o_flit is valid
//   o_last_fire  : the tail flit is being accepted this cycle
module ni_tx_serializer
  import ni_bridge_pkg::*;
#(
  parameter int  FLIT_W     = 16,
  parameter int  BODY_FLITS = 3,
  localparam int PKT_W      = FLIT_W * (BODY_FLITS + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_send,
  input  logic [PKT_W-1:0]  i_rdata,
  input  logic              i_ready,
  output logic [FLIT_W-1:0] o_flit,
  output logic              o_valid,
  output logic              o_last_fire
);

  localparam int CNT_W = $clog2(BODY_FLITS + 2);

  logic [PKT_W-1:0]  r_buf;
  logic [CNT_W-1:0]  r_idx;
  logic [FLIT_W-1:0] r_flit;
  logic              w_fire;

  assign o_valid     = i_send;
  assign o_flit      = r_flit;
  assign w_fire      = i_send & i_ready;
  assign o_last_fire = w_fire & (r_idx == CNT_W'(BODY_FLITS + 1));

  // The current flit always sits in the low FLIT_W bits of r_buf; r_flit is a
  // registered copy so o_flit has no logic in front of it and only changes on
  // load or on an accepted flit, which keeps it stable through stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_flit <= '0;
    end else if (i_load) begin
      r_buf  <= i_rdata;
      r_flit <= i_rdata[FLIT_W-1:0];
      r_idx  <= '0;
    end else if (w_fire) begin
      r_buf  <= r_buf >> FLIT_W;
      r_flit <= r_buf[2*FLIT_W-1:FLIT_W];
      if (!o_last_fire) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ni_flit_bridge.sv
// NoC network interface bridge.
// Request path: deserialises head/body/tail flits from the NoC into one packet
// word and writes it to the request FIFO, flagging flit-type violations.
// Response path: pops packet words from the response FIFO and serialises them
// onto the NoC.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   in_flit/in_valid/in_ready       : flit stream from the NoC
//   out_flit/out_valid/out_ready    : flit stream to the NoC
//   req_fifo_wdata/wreq/full        : request FIFO write side
//   resp_fifo_rdata/rreq/empty      : response FIFO read side (rdata valid the cycle after rreq)
//   proto_err                       : one-cycle pulse on an unexpected flit type
//
// Request FSM
//   state    | meaning
//   RX_HEAD  | waiting for a HEAD flit; other types are dropped with proto_err
//   RX_BODY  | collecting BODY_FLITS body flits
//   RX_TAIL  | waiting for the TAIL flit
//   RX_WRITE | packet complete, writing to the request FIFO (holds while full)
//
// Response FSM
//   state    | meaning
//   TX_IDLE  | waiting for the response FIFO to become non-empty
//   TX_RREQ  | one-cycle read strobe to the response FIFO
//   TX_LOAD  | FIFO data valid, captured by the serialiser
//   TX_SEND  | serialiser presenting flits until the tail is accepted
module ni_flit_bridge
  import ni_bridge_pkg::*;
#(
  parameter int  FLIT_W     = 16,
  parameter int  BODY_FLITS = 3,
  localparam int PKT_W      = FLIT_W * (BODY_FLITS + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  req_fifo_wdata,
  output logic              req_fifo_wreq,
  input  logic              req_fifo_full,
  input  logic [PKT_W-1:0]  resp_fifo_rdata,
  output logic              resp_fifo_rreq,
  input  logic              resp_fifo_empty,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(BODY_FLITS + 2);

  ni_rx_state_e     r_rx_state;
  ni_rx_state_e     w_rx_next;
  ni_tx_state_e     r_tx_state;
  ni_tx_state_e     w_tx_next;
  logic [CNT_W-1:0] r_body_cnt;
  logic [PKT_W-1:0] r_pkt;
  logic             r_live;
  logic             w_active;
  logic             w_rx_fire;
  flit_type_e       w_in_type;
  logic             w_st_head;
  logic             w_st_body;
  logic             w_st_tail;
  logic             w_tx_load;
  logic             w_tx_send;
  logic             w_tx_last;

  // r_live is low on the first cycle after reset so the bridge stays quiet
  // for one full cycle once reset drops.
  assign w_active       = r_live & ~reset;
  assign in_ready       = w_active & (r_rx_state != RX_WRITE);
  assign w_rx_fire      = in_valid & in_ready;
  assign w_in_type      = flit_type(FLIT_MAX_W'(in_flit), FLIT_W);
  assign req_fifo_wdata = r_pkt;

  always_comb begin
    w_rx_next     = r_rx_state;
    req_fifo_wreq = 1'b0;
    proto_err     = 1'b0;
    w_st_head     = 1'b0;
    w_st_body     = 1'b0;
    w_st_tail     = 1'b0;
    case (r_rx_state)
      RX_HEAD: begin
        if (w_rx_fire) begin
          if (w_in_type == HEAD) begin
            w_st_head = 1'b1;
            w_rx_next = RX_BODY;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      RX_BODY: begin
        if (w_rx_fire) begin
          if (w_in_type == BODY) begin
            w_st_body = 1'b1;
            if (r_body_cnt == CNT_W'(BODY_FLITS - 1)) begin
              w_rx_next = RX_TAIL;
            end
          end else begin
            // The offending flit is consumed; the partial packet is abandoned.
            proto_err = 1'b1;
            w_rx_next = RX_HEAD;
          end
        end
      end
      RX_TAIL: begin
        if (w_rx_fire) begin
          if (w_in_type == TAIL) begin
            w_st_tail = 1'b1;
            w_rx_next = RX_WRITE;
          end else begin
            proto_err = 1'b1;
            w_rx_next = RX_HEAD;
          end
        end
      end
      RX_WRITE: begin
        req_fifo_wreq = ~req_fifo_full & ~reset;
        if (req_fifo_wreq) begin
          w_rx_next = RX_HEAD;
        end
      end
      default: w_rx_next = RX_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_HEAD;
      r_body_cnt <= '0;
      r_pkt      <= '0;
      r_live     <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      r_rx_state <= w_rx_next;
      if (w_st_head) begin
        r_pkt[FLIT_W-1:0] <= in_flit;
        r_body_cnt        <= '0;
      end
      if (w_st_body) begin
        // Constant-index slots keep the write decode a plain compare per body flit.
        for (int k = 0; k < BODY_FLITS; k++) begin
          if (r_body_cnt == CNT_W'(k)) begin
            r_pkt[(k+1)*FLIT_W +: FLIT_W] <= in_flit;
          end
        end
        r_body_cnt <= r_body_cnt + 1'b1;
      end
      if (w_st_tail) begin
        r_pkt[PKT_W-1 -: FLIT_W] <= in_flit;
      end
    end
  end

  assign resp_fifo_rreq = (r_tx_state == TX_RREQ) & ~reset;
  assign w_tx_load      = (r_tx_state == TX_LOAD);
  assign w_tx_send      = (r_tx_state == TX_SEND) & ~reset;

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (!resp_fifo_empty) w_tx_next = TX_RREQ;
      TX_RREQ: w_tx_next = TX_LOAD;
      TX_LOAD: w_tx_next = TX_SEND;
      TX_SEND: if (w_tx_last) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  ni_tx_serializer #(
    .FLIT_W     (FLIT_W),
    .BODY_FLITS (BODY_FLITS)
  ) u_tx_ser (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_tx_load),
    .i_send      (w_tx_send),
    .i_rdata     (resp_fifo_rdata),
    .i_ready     (out_ready),
    .o_flit      (out_flit),
    .o_valid     (out_valid),
    .o_last_fire (w_tx_last)
  );

endmodule

// File: tb/tb_ni_flit_bridge.sv
module tb_ni_flit_bridge;

  localparam int FW = 16;
  localparam int BF = 3;
  localparam int PW = FW * (BF + 2);

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] req_fifo_wdata;
  logic          req_fifo_wreq;
  logic          req_fifo_full;
  logic [PW-1:0] resp_fifo_rdata;
  logic          resp_fifo_rreq;
  logic          resp_fifo_empty;
  logic          proto_err;

  always #5 clk = ~clk;

  ni_flit_bridge #(.FLIT_W(FW), .BODY_FLITS(BF)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_flit         (in_flit),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_flit        (out_flit),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .req_fifo_wdata  (req_fifo_wdata),
    .req_fifo_wreq   (req_fifo_wreq),
    .req_fifo_full   (req_fifo_full),
    .resp_fifo_rdata (resp_fifo_rdata),
    .resp_fifo_rreq  (resp_fifo_rreq),
    .resp_fifo_empty (resp_fifo_empty),
    .proto_err       (proto_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [PW-1:0] exp_req[$];
  logic [FW-1:0] exp_tx[$];
  logic [PW-1:0] fifo_q[$];

  int   cyc       = 0;
  int   proto_cnt = 0;
  int   rreq_cnt  = 0;
  bit   tog_en    = 1'b0;
  bit   lat_armed = 1'b0;
  int   fall_cyc  = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response FIFO model and NoC ready generator.
  initial begin
    bit r;
    out_ready       = 1'b1;
    resp_fifo_empty = 1'b1;
    resp_fifo_rdata = '0;
    forever begin
      @(negedge clk);
      r = resp_fifo_rreq;
      @(posedge clk);
      #1;
      if (r && fifo_q.size() > 0) resp_fifo_rdata = fifo_q.pop_front();
      resp_fifo_empty = (fifo_q.size() == 0);
      out_ready = tog_en ? ~out_ready : 1'b1;
    end
  end

  // Output monitor / scoreboard.
  initial begin
    bit            prev_stall = 1'b0;
    bit            prev_empty = 1'b1;
    logic [FW-1:0] prev_flit  = '0;
    forever begin
      @(negedge clk);
      if (req_fifo_wreq) begin
        if (exp_req.size() > 0) chk("req_pkt", req_fifo_wdata, exp_req.pop_front());
        else chk("wreq_unexpected", req_fifo_wreq, 1'b0);
      end
      if (prev_stall) begin
        chk("tx_hold_valid", out_valid, 1'b1);
        chk("tx_hold_flit", out_flit, prev_flit);
      end
      if (out_valid && out_ready) begin
        if (exp_tx.size() > 0) chk("tx_flit", out_flit, exp_tx.pop_front());
        else chk("tx_unexpected", out_valid, 1'b0);
      end
      if (lat_armed && prev_empty && !resp_fifo_empty && fall_cyc < 0) fall_cyc = cyc;
      if (lat_armed && resp_fifo_rreq) chk("rreq_latency", cyc - fall_cyc, 1);
      if (lat_armed && out_valid) begin
        chk("head_latency", cyc - fall_cyc, 3);
        lat_armed = 1'b0;
      end
      if (proto_err) proto_cnt++;
      if (resp_fifo_rreq) rreq_cnt++;
      prev_stall = out_valid & ~out_ready;
      prev_flit  = out_flit;
      prev_empty = resp_fifo_empty;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the flit was accepted.
  task automatic rx_flit(input logic [FW-1:0] f);
    int n = 0;
    in_flit  = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("rx_accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rx_pkt(input logic [PW-1:0] p, input bit good);
    logic [PW-1:0] v;
    v = p;
    if (good) exp_req.push_back(v);
    for (int i = 0; i < BF + 2; i++) rx_flit(v[i*FW +: FW]);
  endtask

  task automatic push_resp(input logic [PW-1:0] p);
    logic [PW-1:0] v;
    v = p;
    fifo_q.push_back(v);
    for (int i = 0; i < BF + 2; i++) exp_tx.push_back(v[i*FW +: FW]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((exp_req.size() != 0 || exp_tx.size() != 0 || out_valid || fifo_q.size() != 0)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk(tag, exp_req.size() + exp_tx.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_wreq"}, req_fifo_wreq, 1'b0);
    chk({tag, "_rreq"}, resp_fifo_rreq, 1'b0);
    chk({tag, "_proto"}, proto_err, 1'b0);
    chk({tag, "_out_flit"}, out_flit, 16'h0);
    chk({tag, "_wdata"}, req_fifo_wdata, 80'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [PW-1:0] p2;
    reset         = 1'b1;
    in_flit       = '0;
    in_valid      = 1'b0;
    req_fifo_full = 1'b0;

    // Reset state and the quiet cycle after reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("post_rst");
    @(negedge clk);
    chk("live_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 1: back-to-back legal packet, FIFO not full.
    rx_pkt(80'hC005_8004_8003_8002_4001, 1'b1);
    @(negedge clk);
    chk("t1_in_ready_write", in_ready, 1'b0);
    chk("t1_wreq", req_fifo_wreq, 1'b1);
    @(negedge clk);
    chk("t1_in_ready_back", in_ready, 1'b1);
    chk("t1_wreq_off", req_fifo_wreq, 1'b0);
    @(posedge clk);
    #1;

    // 2: FIFO full for 4 cycles after the tail.
    p2 = 80'hC015_8014_8013_8012_4011;
    req_fifo_full = 1'b1;
    rx_pkt(p2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_wreq_held", req_fifo_wreq, 1'b0);
      chk("t2_in_ready", in_ready, 1'b0);
      chk("t2_wdata", req_fifo_wdata, p2);
    end
    @(posedge clk);
    #1;
    req_fifo_full = 1'b0;
    @(negedge clk);
    chk("t2_wreq_fire", req_fifo_wreq, 1'b1);
    @(negedge clk);
    chk("t2_in_ready_back", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 3: protocol errors, then a legal packet.
    base = proto_cnt;
    rx_flit(16'h8002);
    rx_flit(16'h4001);
    rx_flit(16'hC009);
    @(negedge clk);
    chk("t3_proto_pulses", proto_cnt - base, 2);
    @(posedge clk);
    #1;
    rx_pkt(80'hC025_8024_8023_8022_4021, 1'b1);
    wait_idle("t3_drain");

    // 4: response with out_ready toggling 1,0,1,0...
    base      = rreq_cnt;
    fall_cyc  = -1;
    lat_armed = 1'b1;
    tog_en    = 1'b1;
    push_resp(80'hC0AA_80BB_80CC_80DD_40EE);
    wait_idle("t4_drain");
    chk("t4_rreq_once", rreq_cnt - base, 1);
    chk("t4_lat_seen", lat_armed, 1'b0);
    tog_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 5: full duplex, two responses back to back while a request arrives.
    push_resp(80'hC031_8032_8033_8034_4035);
    push_resp(80'hC041_8042_8043_8044_4045);
    repeat (2) @(posedge clk);
    #1;
    rx_pkt(80'hC055_8054_8053_8052_4051, 1'b1);
    rx_pkt(80'hC065_8064_8063_8062_4061, 1'b1);
    wait_idle("t5_drain");

    // 6: reset mid-packet on both paths.
    push_resp(80'hC071_8072_8073_8074_4075);
    rx_flit(16'h4081);
    rx_flit(16'h8082);
    n = 0;
    base = 0;
    while (base < 2 && n < 50) begin
      @(negedge clk);
      if (out_valid && out_ready) base++;
      n++;
    end
    if (base < 2) chk("t6_tx_timeout", out_valid, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_out_valid", out_valid, 1'b0);
    chk("t6_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("t6_post_rst");
    exp_tx.delete();
    @(posedge clk);
    #1;
    rx_pkt(80'hC095_8094_8093_8092_4091, 1'b1);
    wait_idle("t6_drain");
    repeat (5) @(negedge clk);
    chk("end_tx_quiet", out_valid, 1'b0);
    chk("end_req_q", exp_req.size(), 0);
    chk("end_tx_q", exp_tx.size(), 0);
    chk("end_proto_total", proto_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
